matrix_op_sequencer: RTL and testbench

- Command-driven controller that sequences one matrix operation end-to-end: reads A and B from single-port RAM, drives the operand registers and operation select, launches multi-cycle ops (multiplication) and waits for their done, then writes the selected result back to RAM.
- Replaces the free-running counter FSM and divided clock in the top level. Runs on the main clock with explicit RAM-latency waits.
- Upstream is a valid/ready command source, such as a switch decoder or bus slave. Downstream are the RAM port, the operation units and the result mux.

---
 rtl/matop_pkg.sv | 36 +++
 rtl/matop_wait_counter.sv | 26 ++
 rtl/matrix_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matop_pkg.sv
// Shared op codes, sequencer states and default RAM map for the matrix op sequencer.
package matop_pkg;

    localparam logic [3:0] OP_SUM    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_SCALAR = 4'd3;
    localparam logic [3:0] OP_TRANSP = 4'd4;
    localparam logic [3:0] OP_OPP    = 4'd5;
    localparam logic [3:0] OP_DET2   = 4'd6;
    localparam logic [3:0] OP_DET3   = 4'd7;
    localparam logic [3:0] OP_NONE   = 4'd15;

    localparam int unsigned ADDR_A_DFLT = 0;
    localparam int unsigned ADDR_B_DFLT = 1;
    localparam int unsigned ADDR_R_DFLT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_START,
        ST_WAIT_DONE,
        ST_WRITE,
        ST_FINISH
    } state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matop_wait_counter.sv
// Loadable down-counter that stops at zero; zero_c flags expiry of a wait.
module matop_wait_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command-driven sequencer: read A/B, run the selected op, write the result back.
// Optional macro MATOP_DONE_TIMEOUT_EN bounds the multiplier done wait.
module matrix_op_sequencer
    import matop_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned RAM_W          = 256,
    parameter int unsigned MAT_W          = 200,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned WRITE_HOLD     = 3,
    parameter int unsigned ADDR_A         = ADDR_A_DFLT,
    parameter int unsigned ADDR_B         = ADDR_B_DFLT,
    parameter int unsigned ADDR_R         = ADDR_R_DFLT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_op,
    output logic              cmd_ready,
    output logic              cmd_done,
    output logic              cmd_error,
    output logic              busy,
    output logic [3:0]        op_sel,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [RAM_W-1:0]  ram_q,
    output logic [MAT_W-1:0]  matrix_a,
    output logic [MAT_W-1:0]  matrix_b,
    output logic              mul_start,
    input  logic              mul_done
);

    localparam int unsigned CNT_MAX = max3(READ_LATENCY, WRITE_HOLD, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // Counter is loaded with N-1 so that zero_c is seen on the Nth cycle of a wait.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_HOLD - 1);
`ifdef MATOP_DONE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t             state, state_n;
    logic               cmd_ready_n, cmd_done_n, cmd_error_n, busy_n;
    logic [3:0]         op_sel_n;
    logic [ADDR_W-1:0]  ram_address_n;
    logic               ram_wren_n, mul_start_n;
    logic [MAT_W-1:0]   matrix_a_n, matrix_b_n;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_value;
    logic               cnt_zero_c;
    logic               unused_ram_bits;

    assign unused_ram_bits = ^ram_q[RAM_W-1:MAT_W];

    matop_wait_counter #(.W(CNT_W)) u_wait (
        .clock  (clock),
        .reset  (reset),
        .load   (cnt_load),
        .value  (cnt_value),
        .zero_c (cnt_zero_c)
    );

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            cmd_done    <= 1'b0;
            cmd_error   <= 1'b0;
            busy        <= 1'b0;
            op_sel      <= OP_NONE;
            ram_address <= ADDR_W'(ADDR_A);
            ram_wren    <= 1'b0;
            matrix_a    <= '0;
            matrix_b    <= '0;
            mul_start   <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_ready   <= cmd_ready_n;
            cmd_done    <= cmd_done_n;
            cmd_error   <= cmd_error_n;
            busy        <= busy_n;
            op_sel      <= op_sel_n;
            ram_address <= ram_address_n;
            ram_wren    <= ram_wren_n;
            matrix_a    <= matrix_a_n;
            matrix_b    <= matrix_b_n;
            mul_start   <= mul_start_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n       = state;
        cmd_done_n    = 1'b0;
        cmd_error_n   = 1'b0;
        op_sel_n      = op_sel;
        ram_address_n = ram_address;
        ram_wren_n    = 1'b0;
        matrix_a_n    = matrix_a;
        matrix_b_n    = matrix_b;
        mul_start_n   = 1'b0;
        cnt_load      = 1'b0;
        cnt_value     = '0;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op > OP_DET3) begin
                        cmd_done_n  = 1'b1;
                        cmd_error_n = 1'b1;
                        state_n     = ST_FINISH;
                    end else begin
                        op_sel_n      = cmd_op;
                        ram_address_n = ADDR_W'(ADDR_A);
                        cnt_load      = 1'b1;
                        cnt_value     = RD_LOAD;
                        state_n       = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                if (cnt_zero_c) begin
                    matrix_a_n    = ram_q[MAT_W-1:0];
                    ram_address_n = ADDR_W'(ADDR_B);
                    cnt_load      = 1'b1;
                    cnt_value     = RD_LOAD;
                    state_n       = ST_RD_B;
                end
            end
            ST_RD_B: begin
                if (cnt_zero_c) begin
                    matrix_b_n = ram_q[MAT_W-1:0];
                    if (op_sel == OP_MUL) begin
                        mul_start_n = 1'b1;
                        state_n     = ST_START;
                    end else begin
                        state_n = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                ram_address_n = ADDR_W'(ADDR_R);
                ram_wren_n    = 1'b1;
                cnt_load      = 1'b1;
                cnt_value     = WR_LOAD;
                state_n       = ST_WRITE;
            end
            ST_START: begin
`ifdef MATOP_DONE_TIMEOUT_EN
                cnt_load  = 1'b1;
                cnt_value = TO_LOAD;
`endif
                state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mul_done) begin
                    ram_address_n = ADDR_W'(ADDR_R);
                    ram_wren_n    = 1'b1;
                    cnt_load      = 1'b1;
                    cnt_value     = WR_LOAD;
                    state_n       = ST_WRITE;
                end
`ifdef MATOP_DONE_TIMEOUT_EN
                else if (cnt_zero_c) begin
                    cmd_done_n  = 1'b1;
                    cmd_error_n = 1'b1;
                    state_n     = ST_FINISH;
                end
`endif
            end
            ST_WRITE: begin
                if (cnt_zero_c) begin
                    cmd_done_n = 1'b1;
                    state_n    = ST_FINISH;
                end else begin
                    ram_wren_n = 1'b1;
                end
            end
            ST_FINISH: begin
                op_sel_n      = OP_NONE;
                ram_address_n = ADDR_W'(ADDR_A);
                state_n       = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        cmd_ready_n = (state_n == ST_IDLE);
        busy_n      = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a one-stage RAM and a small result mux model.
module tb_matrix_op_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RAM_W  = 256;
    localparam int unsigned MAT_W  = 200;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [3:0]        cmd_op = 4'd0;
    logic              cmd_ready, cmd_done, cmd_error, busy;
    logic [3:0]        op_sel;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [RAM_W-1:0]  ram_q;
    logic [MAT_W-1:0]  matrix_a, matrix_b;
    logic              mul_start;
    logic              mul_done = 1'b0;

    logic [RAM_W-1:0]  mem [0:255];
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [RAM_W-1:0]  ld_data = '0;
    logic [RAM_W-1:0]  result;

    int checks = 0;
    int failures = 0;

    matrix_op_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .cmd_done    (cmd_done),
        .cmd_error   (cmd_error),
        .busy        (busy),
        .op_sel      (op_sel),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .matrix_a    (matrix_a),
        .matrix_b    (matrix_b),
        .mul_start   (mul_start),
        .mul_done    (mul_done)
    );

    always #5 clock = ~clock;

    // Result mux stand-in: bytewise sum for OP_SUM, xor for anything else
    always_comb begin
        result = '0;
        if (op_sel == 4'd0) begin
            for (int i = 0; i < 25; i++) result[i*8 +: 8] = matrix_a[i*8 +: 8] + matrix_b[i*8 +: 8];
        end else begin
            result[MAT_W-1:0] = matrix_a ^ matrix_b;
        end
    end

    always @(posedge clock) begin
        ram_q <= mem[ram_address];
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_wren) mem[ram_address] <= result;
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] elem);
        logic [RAM_W-1:0] d;
        d = '0;
        for (int i = 0; i < 25; i++) d[i*8 +: 8] = elem;
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({cmd_ready, cmd_done, cmd_error, busy, ram_wren, mul_start} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {cmd_ready, cmd_done, cmd_error, busy, ram_wren, mul_start});
        end
        checks++;
        if (op_sel !== 4'd15 || ram_address !== 8'd0) begin
            failures++;
            $display("FAIL reset_opsel_addr: got %0d/%0d expected 15/0", op_sel, ram_address);
        end
        checks++;
        if (matrix_a !== '0 || matrix_b !== '0) begin
            failures++;
            $display("FAIL reset_matrices: got nonzero expected zero");
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_sum();
        logic [RAM_W-1:0] exp_r;
        int done_k, wren_cnt, bad_addr;
        exp_r = '0;
        for (int i = 0; i < 25; i++) exp_r[i*8 +: 8] = 8'h03;
        preload(8'd0, 8'h01);
        preload(8'd1, 8'h02);
        preload(8'd2, 8'h00);
        done_k = -1; wren_cnt = 0; bad_addr = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 0) begin
                cmd_valid = 1'b0;
                checks++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL sum_busy_after_accept: got busy=%b ready=%b expected 1/0", busy, cmd_ready);
                end
            end
            if (ram_wren) begin
                wren_cnt++;
                if (ram_address !== 8'd2 || op_sel !== 4'd0) bad_addr++;
            end
            if (cmd_done && done_k < 0) begin
                done_k = k;
                checks++;
                if (cmd_error !== 1'b0) begin
                    failures++;
                    $display("FAIL sum_error: got %b expected 0", cmd_error);
                end
            end
            if (k == 9) begin
                checks++;
                if (op_sel !== 4'd15 || cmd_ready !== 1'b1 || ram_address !== 8'd0) begin
                    failures++;
                    $display("FAIL sum_return_idle: got op_sel=%0d ready=%b addr=%0d expected 15/1/0",
                             op_sel, cmd_ready, ram_address);
                end
            end
        end
        checks++;
        if (done_k !== 8) begin
            failures++;
            $display("FAIL sum_done_cycle: got %0d expected 8", done_k);
        end
        checks++;
        if (wren_cnt !== 3) begin
            failures++;
            $display("FAIL sum_wren_cycles: got %0d expected 3", wren_cnt);
        end
        checks++;
        if (bad_addr !== 0) begin
            failures++;
            $display("FAIL sum_write_addr_opsel: got %0d bad cycles expected 0", bad_addr);
        end
        checks++;
        if (mem[2] !== exp_r) begin
            failures++;
            $display("FAIL sum_result: got %h expected %h", mem[2], exp_r);
        end
    endtask

    task automatic test_mul();
        logic [RAM_W-1:0] exp_r;
        int ms_k, ms_cnt, done_k, last_wren_k, early_wren;
        exp_r = '0;
        for (int i = 0; i < 25; i++) exp_r[i*8 +: 8] = 8'h04;
        preload(8'd1, 8'h05);
        ms_k = -1; ms_cnt = 0; done_k = -1; last_wren_k = -1; early_wren = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) cmd_valid = 1'b0;
            if (mul_start) begin
                ms_cnt++;
                if (ms_k < 0) ms_k = k;
            end
            if (ram_wren) begin
                last_wren_k = k;
                if (!mul_done) early_wren++;
            end
            if (cmd_done && done_k < 0) begin
                done_k = k;
                mul_done = 1'b0;
            end
            if (ms_k >= 0 && k == ms_k + 20) mul_done = 1'b1;
        end
        mul_done = 1'b0;
        checks++;
        if (ms_cnt !== 1 || ms_k !== 4) begin
            failures++;
            $display("FAIL mul_start_pulse: got %0d cycles at %0d expected 1 at 4", ms_cnt, ms_k);
        end
        checks++;
        if (early_wren !== 0) begin
            failures++;
            $display("FAIL mul_wren_before_done: got %0d expected 0", early_wren);
        end
        checks++;
        if (done_k !== 28 || last_wren_k !== 27) begin
            failures++;
            $display("FAIL mul_done_cycle: got done=%0d last_wren=%0d expected 28/27", done_k, last_wren_k);
        end
        checks++;
        if (mem[2] !== exp_r) begin
            failures++;
            $display("FAIL mul_result: got %h expected %h", mem[2], exp_r);
        end
    endtask

    task automatic test_invalid();
        int done_k, wren_seen, opsel_bad;
        logic err_at_done;
        done_k = -1; wren_seen = 0; opsel_bad = 0; err_at_done = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd9;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 0) cmd_valid = 1'b0;
            if (ram_wren) wren_seen++;
            if (op_sel !== 4'd15) opsel_bad++;
            if (cmd_done && done_k < 0) begin
                done_k = k;
                err_at_done = cmd_error;
            end
        end
        checks++;
        if (done_k !== 0 || err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL invalid_done_error: got k=%0d err=%b expected 0/1", done_k, err_at_done);
        end
        checks++;
        if (wren_seen !== 0 || opsel_bad !== 0) begin
            failures++;
            $display("FAIL invalid_side_effects: got wren=%0d opsel_bad=%0d expected 0/0", wren_seen, opsel_bad);
        end
    endtask

    task automatic test_reset_mid_write();
        int wren_k;
        wren_k = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd0;
        for (int k = 0; k < 12 && wren_k < 2; k++) begin
            @(negedge clock);
            if (k == 0) cmd_valid = 1'b0;
            if (ram_wren) wren_k++;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ram_wren !== 1'b0 || cmd_done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_flags: got wren=%b done=%b ready=%b busy=%b expected 0/0/1/0",
                     ram_wren, cmd_done, cmd_ready, busy);
        end
        checks++;
        if (matrix_a !== '0 || op_sel !== 4'd15) begin
            failures++;
            $display("FAIL rstmid_state: got op_sel=%0d a_nonzero=%b expected 15/0", op_sel, |matrix_a);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (cmd_done !== 1'b0 || ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet: got done=%b wren=%b expected 0/0", cmd_done, ram_wren);
        end
    endtask

    task automatic test_back_to_back();
        int done1_k, done2_k, opsel_bad;
        logic [3:0] op_at9, op_at10;
        logic rdy9, rdy10;
        done1_k = -1; done2_k = -1; opsel_bad = 0;
        op_at9 = 4'd0; op_at10 = 4'd0; rdy9 = 1'b0; rdy10 = 1'b1;
        preload(8'd1, 8'h02);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (k == 2) cmd_op = 4'd3;
            if (k <= 7 && op_sel !== 4'd0) opsel_bad++;
            if (k == 9) begin op_at9 = op_sel; rdy9 = cmd_ready; end
            if (k == 10) begin op_at10 = op_sel; rdy10 = cmd_ready; cmd_valid = 1'b0; end
            if (cmd_done) begin
                if (done1_k < 0) done1_k = k;
                else if (done2_k < 0) done2_k = k;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (opsel_bad !== 0 || done1_k !== 8) begin
            failures++;
            $display("FAIL b2b_first: got opsel_bad=%0d done=%0d expected 0/8", opsel_bad, done1_k);
        end
        checks++;
        if (op_at9 !== 4'd15 || rdy9 !== 1'b1 || op_at10 !== 4'd3 || rdy10 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got op9=%0d rdy9=%b op10=%0d rdy10=%b expected 15/1/3/0",
                     op_at9, rdy9, op_at10, rdy10);
        end
        checks++;
        if (done2_k !== 18) begin
            failures++;
            $display("FAIL b2b_second_done: got %0d expected 18", done2_k);
        end
    endtask

`ifdef MATOP_DONE_TIMEOUT_EN
    task automatic test_timeout();
        int done_k, wren_seen;
        logic err_at_done;
        done_k = -1; wren_seen = 0; err_at_done = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) cmd_valid = 1'b0;
            if (ram_wren) wren_seen++;
            if (cmd_done && done_k < 0) begin
                done_k = k;
                err_at_done = cmd_error;
            end
        end
        checks++;
        if (done_k !== 21 || err_at_done !== 1'b1 || wren_seen !== 0) begin
            failures++;
            $display("FAIL timeout: got done=%0d err=%b wren=%0d expected 21/1/0", done_k, err_at_done, wren_seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sum();
        test_mul();
        test_invalid();
        test_reset_mid_write();
        test_back_to_back();
`ifdef MATOP_DONE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
